// File: rtl/samp_rr_sched.sv
// Round-robin scheduler that shares one downstream I/Q sample consumer
// among NCH first-word-fall-through sample FIFOs. A channel keeps its grant
// for up to BURST samples. Samples are forwarded through a registered
// valid/ready stage and tagged with the channel they came from.
module samp_rr_sched #(
   parameter int NCH   = 4,
   parameter int BURST = 4,
   parameter int SW    = 24
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [NCH-1:0]          chan_en,
   input  logic [NCH-1:0]          fifo_empty,
   input  logic [NCH*SW-1:0]       fifo_I,
   input  logic [NCH*SW-1:0]       fifo_Q,
   output logic [NCH-1:0]          fifo_PullOut,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SW-1:0]           out_I,
   output logic [SW-1:0]           out_Q,
   output logic [$clog2(NCH)-1:0]  out_chan,
   output logic                    busy
);

   localparam int CW = $clog2(NCH);
   localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t          stateQ;
   logic [CW-1:0]   curQ;
   logic [BW-1:0]   burstCntQ;
   logic            outValidQ;
   logic [SW-1:0]   outIQ;
   logic [SW-1:0]   outQQ;
   logic [CW-1:0]   outChanQ;

   logic [NCH-1:0]  req;
   logic [CW-1:0]   grantD;
   logic            grantFound;
   logic            canLoad;
   logic            lastBeat;
   logic [SW-1:0]   headI;
   logic [SW-1:0]   headQ;

   // A channel requests service only when it is enabled and has data waiting.
   assign req = chan_en & ~fifo_empty;

   // Head-of-FIFO sample of the currently granted channel.
   assign headI = fifo_I[int'(curQ)*SW +: SW];
   assign headQ = fifo_Q[int'(curQ)*SW +: SW];

   // A new sample can be taken when the output stage is free or draining this
   // cycle, and the granted FIFO still has an enabled, non-empty head.
   assign canLoad  = (stateQ == STREAM) && (!outValidQ || out_ready) && req[curQ];
   assign lastBeat = (burstCntQ == LAST_BEAT);

   // Next grant: first requesting channel searching cyclically from cur+1, so
   // the channel that just finished a burst has the lowest priority.
   always_comb begin
      grantD     = curQ;
      grantFound = 1'b0;
      for (int i = 1; i <= NCH; i++) begin
         if (!grantFound && req[(int'(curQ) + i) % NCH]) begin
            grantD     = CW'((int'(curQ) + i) % NCH);
            grantFound = 1'b1;
         end
      end
   end

   // Pull strobe is one-hot on the granted channel and suppressed during reset
   // so no FIFO word is consumed while the held sample is being discarded.
   always_comb begin
      fifo_PullOut = '0;
      if (canLoad && !Reset) begin
         fifo_PullOut[curQ] = 1'b1;
      end
   end

   // Grant FSM together with the registered output stage. The output register
   // drains independently of the grant state, so a sample held across an IDLE
   // bubble stays valid until the consumer takes it.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         stateQ    <= IDLE;
         curQ      <= CW'(NCH - 1);
         burstCntQ <= '0;
         outValidQ <= 1'b0;
         outIQ     <= '0;
         outQQ     <= '0;
         outChanQ  <= '0;
      end else begin
         if (canLoad) begin
            outIQ     <= headI;
            outQQ     <= headQ;
            outChanQ  <= curQ;
            outValidQ <= 1'b1;
         end else if (outValidQ && out_ready) begin
            outValidQ <= 1'b0;
         end

         case (stateQ)
            IDLE: begin
               if (|req) begin
                  curQ      <= grantD;
                  burstCntQ <= '0;
                  stateQ    <= STREAM;
               end
            end
            STREAM: begin
               if (canLoad) begin
                  burstCntQ <= burstCntQ + 1'b1;
                  if (lastBeat) begin
                     stateQ <= IDLE;
                  end
               end else if (!req[curQ]) begin
                  stateQ <= IDLE;
               end
            end
            default: begin
               stateQ <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = outValidQ;
   assign out_I     = outIQ;
   assign out_Q     = outQQ;
   assign out_chan  = outChanQ;
   assign busy      = (stateQ == STREAM);

endmodule

// File: tb/tb_samp_rr_sched.sv
// Directed testbench for samp_rr_sched. A small FIFO model feeds each channel
// with samples I = ch*16 + n, Q = ~I; accepted outputs and pulls are logged
// and compared against hand-derived burst orders.
module tb_samp_rr_sched;

   localparam int NCH   = 4;
   localparam int BURST = 4;
   localparam int SW    = 24;

   logic              Clk = 1'b0;
   logic              Reset;
   logic [NCH-1:0]    chan_en;
   logic [NCH-1:0]    fifo_empty;
   logic [NCH*SW-1:0] fifo_I;
   logic [NCH*SW-1:0] fifo_Q;
   logic [NCH-1:0]    fifo_PullOut;
   logic              out_valid;
   logic              out_ready;
   logic [SW-1:0]     out_I;
   logic [SW-1:0]     out_Q;
   logic [1:0]        out_chan;
   logic              busy;

   int depth[NCH];
   int pullBase[NCH];
   int pullCount[NCH];
   int cycle;
   int ohViol;
   int emptyViol;
   int enViol;
   int bpViol;

   logic [63:0] accLog[$];
   int          pullCh[$];
   int          pullCyc[$];
   int          accStart;
   int          pullStart;

   int checks;
   int errors;

   samp_rr_sched #(.NCH(NCH), .BURST(BURST), .SW(SW)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .chan_en      (chan_en),
      .fifo_empty   (fifo_empty),
      .fifo_I       (fifo_I),
      .fifo_Q       (fifo_Q),
      .fifo_PullOut (fifo_PullOut),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_I        (out_I),
      .out_Q        (out_Q),
      .out_chan     (out_chan),
      .busy         (busy)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 Clk = ~Clk;

   // FIFO model: head index is the number of pulls since the scenario began.
   always_comb begin
      fifo_empty = '0;
      fifo_I     = '0;
      fifo_Q     = '0;
      for (int k = 0; k < NCH; k++) begin
         fifo_empty[k]       = (pullCount[k] - pullBase[k]) >= depth[k];
         fifo_I[k*SW +: SW]  = SW'(k*16 + pullCount[k] - pullBase[k]);
         fifo_Q[k*SW +: SW]  = ~(SW'(k*16 + pullCount[k] - pullBase[k]));
      end
   end

   // Monitor: counts pulls, logs accepted samples and tallies protocol violations.
   always @(posedge Clk) begin
      cycle <= cycle + 1;
      for (int k = 0; k < NCH; k++) begin
         if (fifo_PullOut[k]) begin
            pullCount[k] <= pullCount[k] + 1;
            pullCh.push_back(k);
            pullCyc.push_back(cycle);
         end
      end
      if (!$onehot0(fifo_PullOut))             ohViol    <= ohViol + 1;
      if (|(fifo_PullOut & fifo_empty))        emptyViol <= emptyViol + 1;
      if (|(fifo_PullOut & ~chan_en))          enViol    <= enViol + 1;
      if (out_valid && !out_ready && |fifo_PullOut) bpViol <= bpViol + 1;
      if (!Reset && out_valid && out_ready)
         accLog.push_back({8'(out_chan), out_I, out_Q});
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] expSample(input int ch, input int n);
      logic [SW-1:0] v;
      v = SW'(ch*16 + n);
      return {8'(ch), v, ~v};
   endfunction

   // Reset the DUT, preload the FIFO model and release with the given enables.
   task automatic applyStimulus(input logic [NCH-1:0] en, input int d0, input int d1,
                                input int d2, input int d3);
      Reset     = 1'b1;
      chan_en   = '0;
      out_ready = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      depth[0] = d0; depth[1] = d1; depth[2] = d2; depth[3] = d3;
      for (int k = 0; k < NCH; k++) pullBase[k] = pullCount[k];
      accStart  = accLog.size();
      pullStart = pullCh.size();
      chan_en   = en;
      Reset     = 1'b0;
   endtask

   task automatic waitAccepted(input int n, input int budget, input string tag);
      int c;
      c = 0;
      while ((accLog.size() - accStart) < n && c < budget) begin
         @(negedge Clk);
         c++;
      end
      if ((accLog.size() - accStart) < n)
         checkOutput({tag, "_timeout"}, 64'(accLog.size() - accStart), 64'(n));
   endtask

   task automatic checkBurst(input string tag, input int pos, input int ch, input int n0, input int len);
      logic [63:0] obs;
      for (int j = 0; j < len; j++) begin
         obs = (accStart + pos + j < accLog.size()) ? accLog[accStart + pos + j] : '1;
         checkOutput($sformatf("%s_s%0d", tag, pos + j), obs, expSample(ch, n0 + j));
      end
   endtask

   initial begin
      int bad;
      int p;
      int b;
      logic [3:0] readyPat;

      checks = 0;
      errors = 0;

      // Reset state
      Reset     = 1'b1;
      chan_en   = '0;
      out_ready = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      #1;
      checkOutput("rst_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_busy",  64'(busy), 64'd0);
      checkOutput("rst_I",     64'(out_I), 64'd0);
      checkOutput("rst_Q",     64'(out_Q), 64'd0);
      checkOutput("rst_chan",  64'(out_chan), 64'd0);
      checkOutput("rst_pull",  64'(fifo_PullOut), 64'd0);

      // Scenario 1: four full FIFOs, full rotation with one-cycle bubbles
      applyStimulus(4'b1111, 8, 8, 8, 8);
      waitAccepted(32, 400, "s1");
      repeat (6) @(negedge Clk);
      checkOutput("s1_accepted", 64'(accLog.size() - accStart), 64'd32);
      checkOutput("s1_pulls",    64'(pullCh.size() - pullStart), 64'd32);
      for (int q = 0; q < 8; q++) checkBurst("s1", q*4, q % 4, (q / 4) * 4, 4);
      bad = 0;
      for (p = 1; p < 32; p++) begin
         if (pullStart + p < pullCh.size()) begin
            if (pullCyc[pullStart+p] - pullCyc[pullStart+p-1] != ((p % 4 == 0) ? 2 : 1)) bad++;
            if (pullCh[pullStart+p] != (p / 4) % 4) bad++;
         end else begin
            bad++;
         end
      end
      checkOutput("s1_gaps", 64'(bad), 64'd0);
      checkOutput("s1_idle", 64'(busy), 64'd0);

      // Scenario 2: single short FIFO ends its burst on empty
      applyStimulus(4'b1111, 0, 0, 3, 0);
      waitAccepted(3, 40, "s2");
      repeat (4) @(negedge Clk);
      checkOutput("s2_pulls", 64'(pullCount[2] - pullBase[2]), 64'd3);
      checkOutput("s2_total", 64'(pullCh.size() - pullStart), 64'd3);
      bad = 0;
      for (p = 1; p < 3; p++) begin
         if (pullStart + p < pullCyc.size()) begin
            if (pullCyc[pullStart+p] - pullCyc[pullStart+p-1] != 1) bad++;
         end else begin
            bad++;
         end
      end
      checkOutput("s2_consec", 64'(bad), 64'd0);
      checkBurst("s2", 0, 2, 0, 3);
      checkOutput("s2_busy", 64'(busy), 64'd0);

      // Scenario 3: backpressure pattern 1,0,0,1 on a 4-deep channel 1
      applyStimulus(4'b1111, 0, 4, 0, 0);
      readyPat = 4'b1001;
      b = 0;
      while ((accLog.size() - accStart) < 4 && b < 80) begin
         out_ready = readyPat[b % 4];
         @(negedge Clk);
         b++;
      end
      out_ready = 1'b1;
      if ((accLog.size() - accStart) < 4)
         checkOutput("s3_timeout", 64'(accLog.size() - accStart), 64'd4);
      repeat (6) @(negedge Clk);
      checkOutput("s3_accepted", 64'(accLog.size() - accStart), 64'd4);
      checkOutput("s3_pulls", 64'(pullCount[1] - pullBase[1]), 64'd4);
      checkBurst("s3", 0, 1, 0, 4);

      // Scenario 4: only channels 1 and 3 enabled, all FIFOs full
      applyStimulus(4'b1010, 8, 8, 8, 8);
      waitAccepted(16, 200, "s4");
      repeat (6) @(negedge Clk);
      checkBurst("s4", 0,  1, 0, 4);
      checkBurst("s4", 4,  3, 0, 4);
      checkBurst("s4", 8,  1, 4, 4);
      checkBurst("s4", 12, 3, 4, 4);
      checkOutput("s4_ch0", 64'(pullCount[0] - pullBase[0]), 64'd0);
      checkOutput("s4_ch2", 64'(pullCount[2] - pullBase[2]), 64'd0);
      checkOutput("s4_accepted", 64'(accLog.size() - accStart), 64'd16);

      // Scenario 5: reset in the second cycle of a channel 0 burst
      applyStimulus(4'b1111, 8, 8, 8, 8);
      @(negedge Clk);
      #1;
      checkOutput("s5_busyA", 64'(busy), 64'd1);
      checkOutput("s5_pullA", 64'(fifo_PullOut), 64'b0001);
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      checkOutput("s5_pullRst", 64'(fifo_PullOut), 64'd0);
      @(negedge Clk);
      #1;
      checkOutput("s5_valid", 64'(out_valid), 64'd0);
      checkOutput("s5_busy",  64'(busy), 64'd0);
      checkOutput("s5_outI",  64'(out_I), 64'd0);
      accStart  = accLog.size();
      pullStart = pullCh.size();
      Reset = 1'b0;
      #1;
      checkOutput("s5_pullIdle", 64'(fifo_PullOut), 64'd0);
      waitAccepted(4, 40, "s5");
      checkOutput("s5_firstPull", 64'((pullStart < pullCh.size()) ? pullCh[pullStart] : 99), 64'd0);
      checkOutput("s5_ch0pulls", 64'(pullCount[0] - pullBase[0]), 64'd5);
      checkBurst("s5", 0, 0, 1, 4);

      // Protocol invariants accumulated across all scenarios
      checkOutput("onehot0",          64'(ohViol),    64'd0);
      checkOutput("pullWhenEmpty",    64'(emptyViol), 64'd0);
      checkOutput("pullWhenDisabled", 64'(enViol),    64'd0);
      checkOutput("pullBackpressure", 64'(bpViol),    64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
